// File: rtl/ethernet_tx_arbiter_pkg.sv
// Shared constants, FSM state encoding and the TX beat payload for the
// Ethernet TX round-robin arbiter.
package ethernet_tx_arbiter_pkg;

    // Default payload length limit and inter-frame gap
    localparam int unsigned MAX_PAYLOAD_LEN = 1500;
    localparam int unsigned IFG_LEN         = 12;

    // Byte counter covers MAX_FRAME_BYTES up to 2047
    localparam int unsigned BYTE_CNT_W = 11;
    localparam int unsigned STAT_W     = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_XFER  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_IFG   = 2'd3
    } tx_state_e;

    // One byte beat towards the encapsulator
    typedef struct packed {
        logic [7:0] data;
        logic       valid;
        logic       last;
        logic       abort;
    } tx_beat_t;

    // Index width for n entries, never below one bit
    function automatic int unsigned idx_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ethernet_tx_arbiter_rr_pick.sv
// tx_rr_pick: combinational round-robin priority search.
// Searches req upward starting at last_id+1 (mod NUM_REQ) and returns the
// first set bit as a one-hot vector and an index; any flags a hit.
//   req     : request vector
//   last_id : index of the previous winner
//   onehot  : one-hot winner (0 when no request)
//   idx     : winner index
//   any     : at least one request set
module tx_rr_pick
    import ethernet_tx_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_id,
    output logic [NUM_REQ-1:0] onehot,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    int unsigned cand;

    // Rotating scan; the first hit locks out later candidates
    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        cand   = 0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = (32'(last_id) + k) % NUM_REQ;
            if (!any && req[cand[IDX_W-1:0]]) begin
                any    = 1'b1;
                idx    = IDX_W'(cand);
                onehot = NUM_REQ'(1) << cand;
            end
        end
    end

endmodule

// File: rtl/ethernet_tx_arbiter.sv
// ethernet_tx_arbiter: round-robin scheduler sharing the TX encapsulation
// datapath among NUM_REQ byte-stream sources. Enforces a per-grant byte
// limit (truncating with m_abort) and an idle gap after every frame.
//   clk, rst                : clock, synchronous active-high reset
//   s_data/s_valid/s_last   : per-requester byte lanes (valid doubles as request)
//   s_ready                 : per-requester accept
//   m_data/m_valid/m_last   : byte stream to the encapsulator
//   m_abort                 : qualifies m_last, frame truncated
//   m_ready                 : encapsulator accept
//   grant                   : registered one-hot grant
//   busy                    : FSM not idle
//   frame_count/abort_count : wrapping completed / truncated frame counts
module ethernet_tx_arbiter
    import ethernet_tx_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ         = 4,
    parameter int unsigned MAX_FRAME_BYTES = MAX_PAYLOAD_LEN,
    parameter int unsigned IFG_CYCLES      = IFG_LEN
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [8*NUM_REQ-1:0] s_data,
    input  logic [NUM_REQ-1:0]   s_valid,
    input  logic [NUM_REQ-1:0]   s_last,
    output logic [NUM_REQ-1:0]   s_ready,
    output logic [7:0]           m_data,
    output logic                 m_valid,
    output logic                 m_last,
    output logic                 m_abort,
    input  logic                 m_ready,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 busy,
    output logic [STAT_W-1:0]    frame_count,
    output logic [STAT_W-1:0]    abort_count
);

    localparam int unsigned IDX_W = idx_width(NUM_REQ);
    localparam int unsigned IFG_W = idx_width(IFG_CYCLES + 1);

    tx_state_e              state_q, state_d;
    logic [NUM_REQ-1:0]     grant_q, grant_d;
    logic [IDX_W-1:0]       last_id_q, last_id_d;
    logic [BYTE_CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
    logic [IFG_W-1:0]       ifg_cnt_q, ifg_cnt_d;
    logic [STAT_W-1:0]      frame_cnt_q, frame_cnt_d;
    logic [STAT_W-1:0]      abort_cnt_q, abort_cnt_d;

    logic [NUM_REQ-1:0]     pick_onehot;
    logic [IDX_W-1:0]       pick_idx;
    logic                   pick_any;

    logic [7:0]             lane_data;
    logic                   lane_valid;
    logic                   lane_last;
    logic                   at_limit;
    tx_beat_t               beat;

    tx_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req     (s_valid),
        .last_id (last_id_q),
        .onehot  (pick_onehot),
        .idx     (pick_idx),
        .any     (pick_any)
    );

    // Granted-lane mux; last_id holds the current owner while busy
    always_comb begin
        lane_data  = '0;
        lane_valid = 1'b0;
        lane_last  = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (last_id_q == IDX_W'(i)) begin
                lane_data  = s_data[8*i +: 8];
                lane_valid = s_valid[i];
                lane_last  = s_last[i];
            end
        end
    end

    assign at_limit = (byte_cnt_q == BYTE_CNT_W'(MAX_FRAME_BYTES - 1));

    // Next-state, register updates and combinational stream outputs
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_id_d   = last_id_q;
        byte_cnt_d  = byte_cnt_q;
        ifg_cnt_d   = ifg_cnt_q;
        frame_cnt_d = frame_cnt_q;
        abort_cnt_d = abort_cnt_q;
        beat        = '0;
        s_ready     = '0;

        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    grant_d    = pick_onehot;
                    last_id_d  = pick_idx;
                    byte_cnt_d = '0;
                    state_d    = ST_XFER;
                end
            end

            ST_XFER: begin
                beat.data  = lane_data;
                beat.valid = lane_valid;
                beat.last  = lane_last;
                s_ready    = grant_q & {NUM_REQ{m_ready}};
                // A genuine last byte wins over truncation at the limit
                if (at_limit && !lane_last) begin
                    beat.last  = 1'b1;
                    beat.abort = 1'b1;
                end
                if (lane_valid && m_ready) begin
                    byte_cnt_d = byte_cnt_q + BYTE_CNT_W'(1);
                    if (lane_last) begin
                        frame_cnt_d = frame_cnt_q + STAT_W'(1);
                        grant_d     = '0;
                        ifg_cnt_d   = '0;
                        state_d     = ST_IFG;
                    end else if (at_limit) begin
                        abort_cnt_d = abort_cnt_q + STAT_W'(1);
                        state_d     = ST_DRAIN;
                    end
                end
            end

            ST_DRAIN: begin
                // Swallow the over-length tail up to the source's last byte
                s_ready = grant_q;
                if (lane_valid && lane_last) begin
                    grant_d   = '0;
                    ifg_cnt_d = '0;
                    state_d   = ST_IFG;
                end
            end

            ST_IFG: begin
                if (ifg_cnt_q == IFG_W'(IFG_CYCLES - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    ifg_cnt_d = ifg_cnt_q + IFG_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            last_id_q   <= IDX_W'(NUM_REQ - 1);
            byte_cnt_q  <= '0;
            ifg_cnt_q   <= '0;
            frame_cnt_q <= '0;
            abort_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            last_id_q   <= last_id_d;
            byte_cnt_q  <= byte_cnt_d;
            ifg_cnt_q   <= ifg_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            abort_cnt_q <= abort_cnt_d;
        end
    end

    assign m_data      = beat.data;
    assign m_valid     = beat.valid;
    assign m_last      = beat.last;
    assign m_abort     = beat.abort;
    assign grant       = grant_q;
    assign busy        = (state_q != ST_IDLE);
    assign frame_count = frame_cnt_q;
    assign abort_count = abort_cnt_q;

endmodule

// File: tb/tb_ethernet_tx_arbiter.sv
// Directed testbench for ethernet_tx_arbiter (4 requesters, 1500-byte
// limit, 12-cycle gap). Sources are modelled by per-requester position
// counters; outputs are sampled on the falling edge.
module tb_ethernet_tx_arbiter;

    localparam int N    = 4;
    localparam int MAXB = 1500;
    localparam int IFG  = 12;

    logic           clk = 1'b0;
    logic           rst;
    logic [8*N-1:0] s_data;
    logic [N-1:0]   s_valid, s_last, s_ready;
    logic [7:0]     m_data;
    logic           m_valid, m_last, m_abort, m_ready;
    logic [N-1:0]   grant;
    logic           busy;
    logic [15:0]    frame_count, abort_count;

    always #5 clk = ~clk;

    ethernet_tx_arbiter #(
        .NUM_REQ         (N),
        .MAX_FRAME_BYTES (MAXB),
        .IFG_CYCLES      (IFG)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_last      (s_last),
        .s_ready     (s_ready),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_last      (m_last),
        .m_abort     (m_abort),
        .m_ready     (m_ready),
        .grant       (grant),
        .busy        (busy),
        .frame_count (frame_count),
        .abort_count (abort_count)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int src_len[N];
    int src_pos[N];
    int src_frames[N];

    // Snapshot of DUT outputs taken on the falling edge
    logic [N-1:0] o_grant, o_sready, o_svalid;
    logic [7:0]   o_mdata;
    logic         o_mvalid, o_mlast, o_mabort, o_busy, o_xfer, o_mready;
    logic [15:0]  o_fc, o_ac;
    int           o_cyc;

    function automatic logic [7:0] byte_of(input int r, input int k);
        return 8'(r * 37 + k * 5 + 1);
    endfunction

    function automatic int oh2idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic drive_sources();
        for (int i = 0; i < N; i++) begin
            s_valid[i]        = (src_frames[i] > 0);
            s_last[i]         = (src_frames[i] > 0) && (src_pos[i] == src_len[i] - 1);
            s_data[8*i +: 8]  = byte_of(i, src_pos[i]);
        end
    endtask

    task automatic clear_sources();
        for (int i = 0; i < N; i++) begin
            src_len[i]    = 1;
            src_pos[i]    = 0;
            src_frames[i] = 0;
        end
        drive_sources();
    endtask

    // Sample on negedge, then advance sources that were accepted at posedge
    task automatic tick();
        logic [N-1:0] acc;
        @(negedge clk);
        o_grant  = grant;    o_sready = s_ready;  o_svalid = s_valid;
        o_mdata  = m_data;   o_mvalid = m_valid;  o_mlast  = m_last;
        o_mabort = m_abort;  o_busy   = busy;     o_fc     = frame_count;
        o_ac     = abort_count;  o_mready = m_ready;
        o_xfer   = m_valid & m_ready;
        o_cyc    = cyc;
        cyc++;
        acc = s_valid & s_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc[i]) begin
                if (src_pos[i] == src_len[i] - 1) begin
                    src_pos[i] = 0;
                    src_frames[i]--;
                end else begin
                    src_pos[i]++;
                end
            end
        end
        drive_sources();
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        m_ready = 1'b1;
        clear_sources();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        m_ready = 1'b1;
        clear_sources();
        tick();
        tick();
        checks++; if (o_grant !== 4'b0000) begin errors++; $display("FAIL reset_grant: got %b expected 0000", o_grant); end
        checks++; if (o_sready !== 4'b0000) begin errors++; $display("FAIL reset_s_ready: got %b expected 0000", o_sready); end
        checks++; if ({o_mvalid, o_mlast, o_mabort} !== 3'b000) begin errors++; $display("FAIL reset_m_flags: got %b expected 000", {o_mvalid, o_mlast, o_mabort}); end
        checks++; if (o_mdata !== 8'h00) begin errors++; $display("FAIL reset_m_data: got %h expected 00", o_mdata); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", o_busy); end
        checks++; if (o_fc !== 16'd0 || o_ac !== 16'd0) begin errors++; $display("FAIL reset_counts: got %0d/%0d expected 0/0", o_fc, o_ac); end
        rst = 1'b0;
        tick();
        checks++; if (o_busy !== 1'b0 || o_grant !== 4'b0000) begin errors++; $display("FAIL idle_no_request: got busy %b grant %b expected 0 0000", o_busy, o_grant); end
    endtask

    task automatic test_single_frame();
        int  nb = 0;
        int  n_busy = 0;
        bit  done = 0;
        do_reset();
        src_len[1] = 64; src_frames[1] = 1;
        drive_sources();
        tick();
        checks++; if (o_grant !== 4'b0000) begin errors++; $display("FAIL single_grant_early: got %b expected 0000", o_grant); end
        tick();
        checks++; if (o_grant !== 4'b0010) begin errors++; $display("FAIL single_grant: got %b expected 0010", o_grant); end
        for (int t = 0; t < 200 && !done; t++) begin
            if (t > 0) tick();
            if (o_xfer) begin
                checks++; if (o_mdata !== byte_of(1, nb)) begin errors++; $display("FAIL single_data[%0d]: got %h expected %h", nb, o_mdata, byte_of(1, nb)); end
                checks++; if (o_mlast !== (nb == 63) || o_mabort !== 1'b0) begin errors++; $display("FAIL single_last_abort[%0d]: got %b%b expected %b0", nb, o_mlast, o_mabort, nb == 63); end
                nb++;
                if (o_mlast) done = 1;
            end
        end
        checks++; if (nb !== 64) begin errors++; $display("FAIL single_bytes: got %0d expected 64", nb); end
        tick();
        checks++; if (o_fc !== 16'd1 || o_grant !== 4'b0000) begin errors++; $display("FAIL single_end: got fc %0d grant %b expected 1 0000", o_fc, o_grant); end
        for (int t = 0; t < 50; t++) begin
            if (!o_busy) break;
            n_busy++;
            tick();
        end
        checks++; if (n_busy !== IFG) begin errors++; $display("FAIL single_ifg_busy: got %0d expected %0d", n_busy, IFG); end
    endtask

    task automatic test_round_robin();
        int           exp_order[5] = '{0, 1, 2, 3, 0};
        int           order[5];
        int           n_g = 0;
        int           last_cyc = 0;
        logic [N-1:0] prev = '0;
        do_reset();
        for (int r = 0; r < N; r++) src_len[r] = 46;
        src_frames[0] = 2; src_frames[1] = 1; src_frames[2] = 1; src_frames[3] = 1;
        drive_sources();
        for (int t = 0; t < 1000; t++) begin
            tick();
            if (o_grant != 0 && prev == 0 && n_g < 5) begin
                order[n_g] = oh2idx(o_grant);
                // last byte taken at edge after last_cyc; grant latched at edge before o_cyc
                if (n_g > 0) begin
                    checks++; if (o_cyc - (last_cyc + 1) !== IFG + 1) begin errors++; $display("FAIL rr_gap[%0d]: got %0d expected %0d", n_g, o_cyc - (last_cyc + 1), IFG + 1); end
                end
                n_g++;
            end
            if (o_xfer && o_mlast) last_cyc = o_cyc;
            prev = o_grant;
            if (n_g == 5 && o_fc == 16'd5) break;
        end
        checks++; if (n_g !== 5) begin errors++; $display("FAIL rr_grants: got %0d expected 5", n_g); end
        for (int k = 0; k < 5 && k < n_g; k++) begin
            checks++; if (order[k] !== exp_order[k]) begin errors++; $display("FAIL rr_order[%0d]: got %0d expected %0d", k, order[k], exp_order[k]); end
        end
        checks++; if (o_fc !== 16'd5) begin errors++; $display("FAIL rr_frames: got %0d expected 5", o_fc); end
    endtask

    task automatic test_abort();
        int nb = 0, drained = 0, leak = 0, early = 0;
        bit lim_last = 0, lim_abort = 0;
        do_reset();
        src_len[2] = 1600; src_frames[2] = 1;
        drive_sources();
        for (int t = 0; t < 2500 && src_frames[2] > 0; t++) begin
            tick();
            if (o_xfer) begin
                if (nb == MAXB - 1) begin lim_last = o_mlast; lim_abort = o_mabort; end
                else if (o_mlast || o_mabort) early++;
                nb++;
            end else if (o_sready[2] && o_svalid[2]) begin
                drained++;
            end
            if (nb >= MAXB && o_mvalid && !o_xfer) leak++;
            if (nb > MAXB) leak++;
        end
        checks++; if (nb !== MAXB) begin errors++; $display("FAIL abort_fwd_bytes: got %0d expected %0d", nb, MAXB); end
        checks++; if ({lim_last, lim_abort} !== 2'b11) begin errors++; $display("FAIL abort_limit_byte: got last/abort %b%b expected 11", lim_last, lim_abort); end
        checks++; if (early !== 0) begin errors++; $display("FAIL abort_early_flags: got %0d expected 0", early); end
        checks++; if (drained !== 100 || leak !== 0) begin errors++; $display("FAIL abort_drain: got %0d drained %0d leaked expected 100 0", drained, leak); end
        tick();
        checks++; if (o_ac !== 16'd1 || o_fc !== 16'd0) begin errors++; $display("FAIL abort_counts: got ac %0d fc %0d expected 1 0", o_ac, o_fc); end
        checks++; if (o_grant !== 4'b0000 || o_busy !== 1'b1) begin errors++; $display("FAIL abort_ifg: got grant %b busy %b expected 0000 1", o_grant, o_busy); end
    endtask

    task automatic test_stall();
        int nb = 0;
        bit seen = 0;
        do_reset();
        src_len[0] = 10; src_frames[0] = 1;
        drive_sources();
        for (int t = 0; t < 10; t++) begin
            tick();
            if (o_grant != 0) begin seen = 1; break; end
        end
        checks++; if (!seen) begin errors++; $display("FAIL stall_grant_timeout: got none expected 0001"); end
        for (int k = 0; k < 20 && seen; k++) begin
            if (k > 0) tick();
            checks++; if (o_sready !== {3'b000, o_mready}) begin errors++; $display("FAIL stall_s_ready[%0d]: got %b expected %b", k, o_sready, {3'b000, o_mready}); end
            if (o_xfer) begin
                checks++; if (o_mdata !== byte_of(0, nb) || o_mlast !== (nb == 9)) begin errors++; $display("FAIL stall_data[%0d]: got %h/%b expected %h/%b", nb, o_mdata, o_mlast, byte_of(0, nb), nb == 9); end
                nb++;
            end
            m_ready = ~m_ready;
        end
        checks++; if (nb !== 10) begin errors++; $display("FAIL stall_count: got %0d expected 10", nb); end
        m_ready = 1'b1;
    endtask

    task automatic test_reset_mid_frame();
        int nb = 0;
        do_reset();
        src_len[2] = 64; src_frames[2] = 1;
        drive_sources();
        for (int t = 0; t < 100 && nb < 30; t++) begin
            tick();
            if (o_xfer) nb++;
        end
        checks++; if (nb !== 30) begin errors++; $display("FAIL midrst_progress: got %0d expected 30", nb); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear_sources();
        src_len[0] = 20; src_frames[0] = 1;
        src_len[3] = 20; src_frames[3] = 1;
        drive_sources();
        tick();
        checks++; if (o_grant !== 4'b0000 || o_busy !== 1'b0) begin errors++; $display("FAIL midrst_state: got grant %b busy %b expected 0000 0", o_grant, o_busy); end
        checks++; if ({o_mvalid, o_mlast, o_mabort} !== 3'b000) begin errors++; $display("FAIL midrst_m_flags: got %b expected 000", {o_mvalid, o_mlast, o_mabort}); end
        checks++; if (o_fc !== 16'd0 || o_ac !== 16'd0) begin errors++; $display("FAIL midrst_counts: got %0d/%0d expected 0/0", o_fc, o_ac); end
        tick();
        checks++; if (o_grant !== 4'b0001) begin errors++; $display("FAIL midrst_regrant: got %b expected 0001", o_grant); end
    endtask

    task automatic test_exact_limit();
        int nb = 0, early = 0;
        bit fin_last = 0, fin_abort = 1;
        do_reset();
        src_len[1] = MAXB; src_frames[1] = 1;
        drive_sources();
        for (int t = 0; t < 1700 && src_frames[1] > 0; t++) begin
            tick();
            if (o_xfer) begin
                if (nb == MAXB - 1) begin fin_last = o_mlast; fin_abort = o_mabort; end
                else if (o_mlast || o_mabort) early++;
                nb++;
            end
        end
        checks++; if (nb !== MAXB || early !== 0) begin errors++; $display("FAIL limit_bytes: got %0d bytes %0d early expected %0d 0", nb, early, MAXB); end
        checks++; if ({fin_last, fin_abort} !== 2'b10) begin errors++; $display("FAIL limit_last_byte: got last/abort %b%b expected 10", fin_last, fin_abort); end
        tick();
        checks++; if (o_fc !== 16'd1 || o_ac !== 16'd0) begin errors++; $display("FAIL limit_counts: got fc %0d ac %0d expected 1 0", o_fc, o_ac); end
    endtask

    initial begin
        rst     = 1'b1;
        m_ready = 1'b1;
        s_data  = '0;
        s_valid = '0;
        s_last  = '0;
        test_reset();
        test_single_frame();
        test_round_robin();
        test_abort();
        test_stall();
        test_reset_mid_frame();
        test_exact_limit();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
